// File: rtl/gat_bram_loader.sv
// rtl/gat_bram_loader.sv - framed word stream to per-target BRAM write strobes (optional GAT_LOADER_CHKSUM_EN)
module gat_bram_loader #(
  parameter int TOP_WIDTH          = 32,
  parameter int H_DATA_DEPTH       = 242101,
  parameter int NODE_INFO_DEPTH    = 13264,
  parameter int WEIGHT_DEPTH       = 22928,
  parameter int SUBGRAPH_IDX_DEPTH = 13264,
  parameter int ADDR_W             = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TOP_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic [1:0]           s_target,
  input  logic                 clr,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic [ADDR_W+1:0]    bram_addra,
  output logic [3:0]           bram_ena,
  output logic [3:0]           bram_wea,
  output logic [3:0]           load_done,
  output logic                 load_err,
  output logic                 busy,
  output logic [31:0]          chksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH0 = (ADDR_W+1)'(H_DATA_DEPTH);
  localparam logic [ADDR_W:0] DEPTH1 = (ADDR_W+1)'(NODE_INFO_DEPTH);
  localparam logic [ADDR_W:0] DEPTH2 = (ADDR_W+1)'(WEIGHT_DEPTH);
  localparam logic [ADDR_W:0] DEPTH3 = (ADDR_W+1)'(SUBGRAPH_IDX_DEPTH);
  localparam logic [ADDR_W:0] ONE_W  = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx, cnt_inc, wr_idx;
  logic [1:0]        tgt, tgt_nx, cur_tgt;
  logic [ADDR_W:0]   depth, wcount;
  logic              accept, wr_go, err_set, done_set, first_beat;

  assign s_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_FLUSH);
  assign accept   = s_valid && s_ready && !clr;
  assign bram_wea = bram_ena;
  assign cnt_inc  = cnt + ADDR_W'(1);
  // The target is only sampled on a frame's first beat; mid-frame it comes from the latch.
  assign cur_tgt  = (state == S_IDLE) ? s_target : tgt;
  assign wcount   = {1'b0, cnt_inc} + ONE_W;

  always_comb begin
    depth = DEPTH0;
    case (cur_tgt)
      2'd0: depth = DEPTH0;
      2'd1: depth = DEPTH1;
      2'd2: depth = DEPTH2;
      default: depth = DEPTH3;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    tgt_nx     = tgt;
    wr_go      = 1'b0;
    wr_idx     = cnt;
    err_set    = 1'b0;
    done_set   = 1'b0;
    first_beat = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          tgt_nx     = s_target;
          cnt_nx     = '0;
          first_beat = 1'b1;
          wr_go      = 1'b1;
          wr_idx     = '0;
          if (!s_last) begin
            state_nx = S_LOAD;
          end else if (depth == ONE_W) begin
            state_nx = S_FLUSH;
          end else begin
            state_nx = S_ERR;
            err_set  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (s_last) begin
            wr_go  = 1'b1;
            wr_idx = cnt_inc;
            cnt_nx = cnt_inc;
            if (wcount == depth) begin
              state_nx = S_FLUSH;
            end else begin
              state_nx = S_ERR;
              err_set  = 1'b1;
            end
          end else if ({1'b0, cnt} == depth - ONE_W) begin
            // Region already full and the frame keeps going: drop the beat.
            state_nx = S_ERR;
            err_set  = 1'b1;
          end else begin
            wr_go  = 1'b1;
            wr_idx = cnt_inc;
            cnt_nx = cnt_inc;
          end
        end
      end
      S_FLUSH: begin
        done_set = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_ERR;
      end
    endcase
    if (clr) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      done_set = 1'b0;
      err_set  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tgt        <= '0;
      bram_ena   <= '0;
      bram_din   <= '0;
      bram_addra <= '0;
      load_done  <= '0;
      load_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      tgt      <= tgt_nx;
      bram_ena <= wr_go ? (4'b0001 << tgt_nx) : 4'b0000;
      if (wr_go) begin
        bram_din   <= s_data;
        bram_addra <= {wr_idx, 2'b00};
      end
      if (clr) begin
        load_done <= '0;
        load_err  <= 1'b0;
      end else begin
        if (first_beat) load_done[s_target] <= 1'b0;
        if (done_set)   load_done[tgt]      <= 1'b1;
        if (err_set)    load_err            <= 1'b1;
      end
    end
  end

`ifdef GAT_LOADER_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum <= '0;
    end else if (clr) begin
      chksum <= '0;
    end else if (first_beat) begin
      chksum <= 32'(s_data);
    end else if (wr_go) begin
      chksum <= chksum + 32'(s_data);
    end
  end
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_gat_bram_loader.sv
// tb/tb_gat_bram_loader.sv - self-checking bench for gat_bram_loader
module tb_gat_bram_loader;

  localparam int AW = 18;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              s_last = 1'b0;
  logic [1:0]        s_target = '0;
  logic              clr = 1'b0;
  logic [31:0]       bram_din;
  logic [AW+1:0]     bram_addra;
  logic [3:0]        bram_ena, bram_wea, load_done;
  logic              load_err, busy;
  logic [31:0]       chksum;

  gat_bram_loader #(
    .TOP_WIDTH(32), .H_DATA_DEPTH(3), .NODE_INFO_DEPTH(4),
    .WEIGHT_DEPTH(4), .SUBGRAPH_IDX_DEPTH(6), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last), .s_target(s_target), .clr(clr),
    .bram_din(bram_din), .bram_addra(bram_addra), .bram_ena(bram_ena),
    .bram_wea(bram_wea), .load_done(load_done), .load_err(load_err),
    .busy(busy), .chksum(chksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    ena;
    logic [3:0]    wea;
    logic [AW+1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } dchg_t;

  typedef struct {
    logic [1:0] tgt;
    int         len;
    int         lastp;
    int         gap;
    int         exp_w;
    logic       exp_err;
  } vec_t;

  int          cyc = 0;
  wr_t         wq[$];
  dchg_t       dq[$];
  logic [3:0]  prev_done = '0;
  logic [31:0] words[0:63];
  int          acc_cyc[0:63];
  int          acc_n;
  logic [3:0]  model_done = '0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_ena != 4'b0000 || bram_wea != 4'b0000) begin
      wq.push_back('{ena: bram_ena, wea: bram_wea, addr: bram_addra, data: bram_din, cyc: cyc});
    end
    if (load_done !== prev_done) begin
      dq.push_back('{cyc: cyc, val: load_done});
      prev_done = load_done;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int depth_of(input logic [1:0] t);
    case (t)
      2'd0: return 3;
      2'd1: return 4;
      2'd2: return 4;
      default: return 6;
    endcase
  endfunction

  // Words written: up to and including s_last if it comes within depth+1 beats, else exactly depth.
  function automatic int exp_writes(input int lastp, input int d);
    if (lastp != 0 && lastp <= d + 1) return lastp;
    return d;
  endfunction

  task automatic do_clr(input logic with_beat);
    s_valid = with_beat;
    s_data  = 32'hdead_beef;
    clr     = 1'b1;
    @(posedge clk); #1;
    clr     = 1'b0;
    s_valid = 1'b0;
    model_done = '0;
  endtask

  // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random gaps
  task automatic run_frame(input logic [1:0] t, input int len, input int lastp,
                           input int gap, input logic fixed);
    acc_n = 0;
    wq.delete();
    dq.delete();
    for (int i = 0; i < len; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        s_valid  = 1'b0;
        s_target = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
      end
      s_valid  = 1'b1;
      s_data   = fixed ? 32'(8'h11 * (i + 1)) : $urandom;
      s_last   = (i + 1 == lastp);
      s_target = (i == 0) ? t : 2'($urandom_range(0, 3));
      @(negedge clk);
      if (!s_ready) break;
      words[acc_n]   = s_data;
      acc_cyc[acc_n] = cyc;
      acc_n++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input logic [1:0] t, input int w, input logic e);
    logic [31:0] sum;
    int n;
    sum = '0;
    model_done[t] = !e;
    chk("wr_count", 64'(wq.size()), 64'(w));
    n = (wq.size() < w) ? wq.size() : w;
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 64'(wq[i].addr), 64'(i * 4));
      chk("wr_data", 64'(wq[i].data), 64'(words[i]));
      chk("wr_ena", 64'(wq[i].ena), 64'(4'b0001 << t));
      chk("wr_wea", 64'(wq[i].wea), 64'(4'b0001 << t));
      chk("wr_cycle", 64'(wq[i].cyc), 64'(acc_cyc[i] + 1));
    end
    for (int i = 0; i < w; i++) sum += words[i];
    chk("load_err", 64'(load_err), 64'(e));
    chk("load_done", 64'(load_done), 64'(model_done));
    chk("s_ready_end", 64'(s_ready), 64'(!e));
    chk("busy_end", 64'(busy), 64'(0));
`ifdef GAT_LOADER_CHKSUM_EN
    chk("chksum", 64'(chksum), 64'(sum));
`else
    chk("chksum_off", 64'(chksum), 64'(0));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'(1));
    chk({tag, "_ena"}, 64'(bram_ena), 64'(0));
    chk({tag, "_wea"}, 64'(bram_wea), 64'(0));
    chk({tag, "_din"}, 64'(bram_din), 64'(0));
    chk({tag, "_addra"}, 64'(bram_addra), 64'(0));
    chk({tag, "_done"}, 64'(load_done), 64'(0));
    chk({tag, "_err"}, 64'(load_err), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_chksum"}, 64'(chksum), 64'(0));
  endtask

  vec_t vecs[8];

  initial begin
    logic [1:0] t;
    int d, len, lastp, mode, w;
    logic e;

    vecs[0] = '{tgt: 2'd2, len: 4, lastp: 4, gap: 0, exp_w: 4, exp_err: 1'b0};
    vecs[1] = '{tgt: 2'd1, len: 3, lastp: 3, gap: 0, exp_w: 3, exp_err: 1'b1};
    vecs[2] = '{tgt: 2'd0, len: 5, lastp: 0, gap: 0, exp_w: 3, exp_err: 1'b1};
    vecs[3] = '{tgt: 2'd3, len: 6, lastp: 6, gap: 1, exp_w: 6, exp_err: 1'b0};
    vecs[4] = '{tgt: 2'd0, len: 1, lastp: 1, gap: 0, exp_w: 1, exp_err: 1'b1};
    vecs[5] = '{tgt: 2'd1, len: 5, lastp: 5, gap: 0, exp_w: 5, exp_err: 1'b1};
    vecs[6] = '{tgt: 2'd0, len: 3, lastp: 3, gap: 2, exp_w: 3, exp_err: 1'b0};
    vecs[7] = '{tgt: 2'd3, len: 8, lastp: 0, gap: 1, exp_w: 6, exp_err: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_rst");

    // Weight frame with fixed data: back-to-back strobes and done two cycles after s_last.
    run_frame(2'd2, 4, 4, 0, 1'b1);
    chk_frame(2'd2, 4, 1'b0);
    for (int i = 1; i < wq.size(); i++) chk("t1_consecutive", 64'(wq[i].cyc), 64'(wq[0].cyc + i));
    chk("t1_done_events", 64'(dq.size()), 64'(1));
    if (dq.size() >= 1) begin
      chk("t1_done_cycle", 64'(dq[0].cyc), 64'(acc_cyc[3] + 2));
      chk("t1_done_val", 64'(dq[0].val), 64'(4'b0100));
    end
`ifdef GAT_LOADER_CHKSUM_EN
    chk("t1_chksum_aa", 64'(chksum), 64'(32'haa));
`endif

    // Short frame lands in ERR; stream is blocked until clr, and a beat alongside clr is dropped.
    do_clr(1'b0);
    run_frame(2'd1, 3, 3, 0, 1'b0);
    chk_frame(2'd1, 3, 1'b1);
    wq.delete();
    s_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("err_no_writes", 64'(wq.size()), 64'(0));
    do_clr(1'b1);
    @(negedge clk);
    chk("clr_s_ready", 64'(s_ready), 64'(1));
    chk("clr_err", 64'(load_err), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("clr_beat_dropped", 64'(wq.size()), 64'(0));
    chk("clr_busy", 64'(busy), 64'(0));

    // Overflow: depth-3 region, 5 beats without s_last.
    run_frame(2'd0, 5, 0, 0, 1'b0);
    chk_frame(2'd0, 3, 1'b1);
    chk("ovf_accepted", 64'(acc_n), 64'(4));
    do_clr(1'b0);

    for (int v = 0; v < 8; v++) begin
      do_clr(1'b0);
      run_frame(vecs[v].tgt, vecs[v].len, vecs[v].lastp, vecs[v].gap, 1'b0);
      chk_frame(vecs[v].tgt, vecs[v].exp_w, vecs[v].exp_err);
    end

    // Done flags persist per target; reloading target 0 drops only bit0 until its frame completes.
    do_clr(1'b0);
    run_frame(2'd0, 3, 3, 0, 1'b0);
    chk_frame(2'd0, 3, 1'b0);
    run_frame(2'd2, 4, 4, 0, 1'b0);
    chk_frame(2'd2, 4, 1'b0);
    chk("two_done", 64'(load_done), 64'(4'b0101));
    run_frame(2'd0, 3, 3, 0, 1'b0);
    chk_frame(2'd0, 3, 1'b0);
    chk("reload_events", 64'(dq.size()), 64'(2));
    if (dq.size() == 2) begin
      chk("reload_drop_cyc", 64'(dq[0].cyc), 64'(acc_cyc[0] + 1));
      chk("reload_drop_val", 64'(dq[0].val), 64'(4'b0100));
      chk("reload_rise_cyc", 64'(dq[1].cyc), 64'(acc_cyc[2] + 2));
      chk("reload_rise_val", 64'(dq[1].val), 64'(4'b0101));
    end

    // Asynchronous reset while a write strobe is on the bus.
    s_valid = 1'b1; s_last = 1'b0; s_target = 2'd3; s_data = 32'h1234_5678;
    @(posedge clk); #1;
    s_data = 32'h9abc_def0;
    @(posedge clk); #2;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    chk("pre_rst_ena", 64'(bram_ena), 64'(4'b1000));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    s_valid = 1'b0;
    model_done = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(2'd3, 6, 6, 0, 1'b0);
    chk_frame(2'd3, 6, 1'b0);

    // Randomized frames against the length-rule model.
    for (int r = 0; r < 30; r++) begin
      t = 2'($urandom_range(0, 3));
      d = depth_of(t);
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        lastp = $urandom_range(1, d + 1);
        len = lastp;
      end else if (mode == 2) begin
        len = d + $urandom_range(1, 3);
        lastp = 0;
      end else begin
        len = d;
        lastp = d;
      end
      run_frame(t, len, lastp, 2, 1'b0);
      w = exp_writes(lastp, d);
      e = !(lastp == d);
      chk_frame(t, w, e);
      if (e || $urandom_range(0, 4) == 0) begin
        do_clr(1'b0);
        chk("rand_clr_done", 64'(load_done), 64'(0));
        chk("rand_clr_err", 64'(load_err), 64'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gat_bram_loader.md
Name: gat_bram_loader

Overview:
- Upstream feeder for the GAT top-level BRAM write ports.
- Accepts a 32-bit valid/ready word stream framed by `s_last`. A 2-bit target tag selects the destination BRAM: H data, H node info, weight or subgraph index.
- Emits one-cycle BRAM write strobes with byte addresses (word index × 4) on a shared data/address bus.
- Raises a sticky per-target load-done flag once a frame of exactly the target's expected depth has been written. These flags drive the accelerator's load-done inputs.

Parameters:
- TOP_WIDTH, 32, stream and BRAM data width.
- H_DATA_DEPTH, 242101, expected words for target 0 (H data).
- NODE_INFO_DEPTH, 13264, expected words for target 1 (H node info).
- WEIGHT_DEPTH, 22928, expected words for target 2 (weights; 16 × 1433).
- SUBGRAPH_IDX_DEPTH, 13264, expected words for target 3 (subgraph index).
- ADDR_W, 18, word-address width; must satisfy 2^ADDR_W ≥ the largest depth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  TOP_WIDTH  stream word.
- s_valid  in  1  word valid.
- s_ready  out  1  loader can accept a word.
- s_last  in  1  final word of the frame.
- s_target  in  2  destination select; sampled on the first beat of a frame only.
- clr  in  1  synchronous clear: aborts any frame, clears done/err flags.
- bram_din  out  TOP_WIDTH  write data.
- bram_addra  out  ADDR_W+2  byte address; bits [1:0] are always 0.
- bram_ena  out  4  one-hot per-target enable.
- bram_wea  out  4  identical to bram_ena.
- load_done  out  4  sticky per-target done flags (bit0 = H data … bit3 = subgraph).
- load_err  out  1  sticky frame-length error.
- busy  out  1  high while in LOAD or FLUSH.
- chksum  out  32  frame checksum (see Optional Feature).

Behaviour:
- Reset values:
  - all outputs 0, except s_ready = 1;
  - FSM in IDLE, word counter 0.
- Handshake:
  - a beat is accepted when s_valid & s_ready;
  - s_ready = 1 in IDLE and LOAD, 0 in FLUSH and ERR.
- Write timing:
  - a beat accepted in cycle N produces bram_ena[tgt] = bram_wea[tgt] = 1 in cycle N+1, for exactly one cycle;
  - bram_din = the beat's data; bram_addra = cnt << 2;
  - all four ena/wea bits are 0 in every other cycle. din/addra hold their last value.
- IDLE:
  - on an accepted beat, latch tgt = s_target, set cnt = 0, clear load_done[tgt], issue the write;
  - if s_last is also set, evaluate the end-of-frame check (single-word frame); otherwise go to LOAD.
- LOAD:
  - each accepted beat writes at cnt+1, then increments cnt;
  - s_target is ignored mid-frame.
- End-of-frame check (on the s_last beat):
  - if the written word count equals DEPTH[tgt], go to FLUSH;
  - otherwise set load_err and go to ERR.
- Overflow: a beat arriving when cnt has already reached DEPTH[tgt]-1 without s_last is not written. load_err is set and the FSM goes to ERR.
- FLUSH:
  - lasts one cycle and lets the final write retire;
  - load_done[tgt] rises in cycle N+2, where N is the s_last acceptance cycle, i.e. one cycle after the last write strobe;
  - then return to IDLE.
- ERR:
  - s_ready = 0 and no writes occur;
  - exited only via clr or reset.
- clr:
  - takes effect next cycle from any state: FSM to IDLE, cnt = 0, load_done = 0, load_err = 0;
  - a beat presented in the same cycle as clr is dropped;
  - a write already issued still completes.
- Reloading an already-done target clears only that target's done bit on its first beat. Other targets' done bits persist.
- busy = (state == LOAD) | (state == FLUSH).
- Asynchronous reset mid-frame discards the frame immediately; no further writes.

Optional Feature:
- Macro: GAT_LOADER_CHKSUM_EN.
- Defined:
  - chksum holds the modulo-2^32 sum of all data words of the current or last frame;
  - it resets to 0 on the first beat of each frame and on clr;
  - it updates in the same cycle as the write strobe.
- Undefined: chksum is tied to 0 and no adder is synthesized.

Test Plan:
- Target 2, depth overridden to 4, words 0x11, 0x22, 0x33, 0x44 (last on the 4th), s_valid held high:
  - bram_ena = 4'b0100 for 4 consecutive cycles at addra 0x0, 0x4, 0x8, 0xC;
  - load_done = 4'b0100 two cycles after the last beat;
  - chksum = 0xAA when the macro is defined.
- Target 1, depth 4, last on the 3rd word: load_err = 1, FSM in ERR, s_ready = 0, further beats produce no ena; clr returns s_ready = 1 and load_err = 0.
- Target 0, depth 3, 5 words without last: exactly 3 writes, then load_err = 1; the 4th beat is not written.
- Target 3 frame with s_valid toggling every other cycle: addresses are contiguous (0, 4, 8, …) and the write count equals the accepted-beat count; s_target changed mid-frame has no effect.
- Load target 0, then target 2: load_done = 4'b0101. Reload target 0: bit0 drops on its first beat, bit2 stays, bit0 re-rises at frame end.
- rst_n asserted mid-frame: all outputs return to reset values immediately; a new frame afterwards starts at addra 0.
